hs4_rr_arbiter: RTL and testbench
=================================

# hs4_rr_arbiter

Round-robin arbiter that shares one downstream 4-phase (return-to-zero) bundled-data channel among NREQ upstream 4-phase requesters. It is the clocked controller between the asynchronous handshake stages and the shared data register and consumer. It picks one requester, captures its data into an internal register, and completes both handshakes in order. It then releases the channel to the next requester.

## Interface
- `NREQ`, default 4: number of requesters; must be at least 2.
- `DATA_W`, default 8: data width per requester.
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `in_req`, input, NREQ: per-requester 4-phase request.
- `in_data`, input, NREQ*DATA_W: requester i occupies bits [i*DATA_W +: DATA_W]. Bundled data; it must be stable while `in_req[i]` is high.
- `in_ack`, output, NREQ: per-requester 4-phase acknowledge.
- `out_req`, output, 1: downstream request.
- `out_ack`, input, 1: downstream acknowledge.
- `out_data`, output, DATA_W: registered copy of the granted requester's data.
- `gnt_id`, output, $clog2(NREQ): index of the current or last granted requester.
- `busy`, output, 1: high in every state except IDLE.

## Operation
- Reset values: `in_ack`=0, `out_req`=0, `out_data`=0, `gnt_id`=0, `busy`=0, state=IDLE, last-grant pointer `ptr`=NREQ-1 (requester 0 wins first). Synchronizer flops clear to 0.
- `req_s` and `ack_s` are the `in_req` and `out_ack` signals after the optional synchronizer (see Configuration).
- **IDLE**
  - If any bit of `req_s` is high, pick the first set index searching from `ptr`+1 upward, wrapping modulo NREQ. Call it g.
  - On that edge: `out_data`<=`in_data`[g], `gnt_id`<=g, `out_req`<=1, go to OUT_REQ.
- **OUT_REQ**
  - Hold `out_req`=1 and hold `out_data`.
  - When `ack_s`=1: `out_req`<=0, `in_ack`[g]<=1, go to RTZ.
- **RTZ**
  - Wait until `ack_s`=0 and `req_s`[g]=0, in either order.
  - Then `in_ack`[g]<=0, `ptr`<=g, go to IDLE.
- Only one `in_ack` bit is ever high at a time. `in_ack` is one-hot or zero.
- Simultaneous requests: resolved strictly by the round-robin order above. Starvation-free; maximum wait is NREQ-1 transactions.
- `in_req`[g] withdrawn during OUT_REQ (a protocol violation): ignored. The downstream transaction completes, and RTZ exits as soon as `ack_s` falls.
- Requests from non-granted requesters that arrive during OUT_REQ or RTZ are held pending. They are evaluated in the next IDLE cycle.
- Reset asserted mid-transaction: all outputs clear immediately, independent of the clock. Transaction state is discarded. The next grant after reset goes to the lowest active index.

## Timing
- Without `ARB_SYNC_EN`: `in_req` high before edge n causes `out_req` and `out_data` to update at edge n.
- With `ARB_SYNC_EN`: the same update happens at edge n+2. `out_ack` to `in_ack` latency grows by 2 edges in the same way.
- Minimum transaction length is 3 edges: IDLE, OUT_REQ, RTZ.
- Back-to-back grants: the IDLE cycle is mandatory, so there is at least 1 cycle with `out_req`=0 between transactions.
- `out_data` is valid from the edge `out_req` rises until the next grant.

## Configuration
- `ARB_SYNC_EN` defined: every bit of `in_req` and `out_ack` passes through a two-flop synchronizer clocked by `clk` and reset by `reset`. Use this when handshake partners are asynchronous or on other clocks.
- `ARB_SYNC_EN` undefined: `in_req` and `out_ack` are used directly, with no added latency. Partners must be synchronous to `clk`.

## Structure
- Package `hs_arb_pkg` holds:
  - the state enum {IDLE, OUT_REQ, RTZ};
  - default constants `HS_NREQ`=4 and `HS_DATA_W`=8;
  - the round-robin next-index function.
- Sub-module `sync2_n`: a 1-bit two-flop synchronizer with asynchronous active-low reset. It is instantiated per bit only when `ARB_SYNC_EN` is defined.

## Test plan
- **Reset check:** hold `reset`=0 with arbitrary inputs. Required: all outputs 0 and `busy`=0. Release reset with no requests; outputs stay 0.
- **Single transaction:** raise `in_req`[2] with data 0xA5 (no sync). Required:
  - `out_req`=1, `out_data`=0xA5, `gnt_id`=2 after 1 edge.
  - Drive `out_ack`=1: `out_req`=0 and `in_ack`=4'b0100.
  - Drop `out_ack` and `in_req`[2]: `in_ack`=0 and `busy`=0.
- **Fairness:** hold all four requests high, re-raising each after its RTZ, with an auto-responding consumer. Required: `gnt_id` sequence 0,1,2,3,0,1,2,3.
- **Pointer wrap:** after a grant to 1, raise `in_req`[1] and `in_req`[3] together. Required: 3 wins, then 1.
- **Reset mid-operation:** assert reset during OUT_REQ. Required: `out_req` and `in_ack` drop with no clock edge. After release, with requests 1 and 3 pending, requester 1 is granted.
- **Latency:** run the same stimulus with `ARB_SYNC_EN` defined and undefined. Required: `out_req` rises 3 edges and 1 edge after `in_req` respectively.

Source files
------------

// File: rtl/hs_arb_pkg.sv
// hs_arb_pkg: shared state encoding, default sizes and round-robin pick for hs4_rr_arbiter
package hs_arb_pkg;
  typedef enum logic [1:0] {IDLE, OUT_REQ, RTZ} state_t;
  localparam int HS_NREQ = 4;
  localparam int HS_DATA_W = 8;
  // First set bit searching from ptr+1 upward, wrapping; ptr itself is checked last.
  function automatic int rr_next(input logic [31:0] req, input int ptr, input int n);
    int idx;
    rr_next = ptr;
    for (int i = n; i >= 1; i--) begin
      idx = (ptr + i) % n;
      if (req[idx]) rr_next = idx;
    end
  endfunction
endpackage

// File: rtl/sync2_n.sv
// sync2_n: 1-bit two-flop synchronizer with asynchronous active-low reset
module sync2_n (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic m;
  // Two-stage shift toward q; both stages clear on reset
  always_ff @(posedge clk or negedge reset)
    if (!reset) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/hs4_rr_arbiter.sv
// hs4_rr_arbiter: round-robin arbiter of NREQ 4-phase requesters onto one 4-phase channel; ARB_SYNC_EN adds 2-flop input synchronizers
module hs4_rr_arbiter
  import hs_arb_pkg::*;
#(
  parameter int NREQ = HS_NREQ,
  parameter int DATA_W = HS_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          in_req,
  input  logic [NREQ*DATA_W-1:0]   in_data,
  output logic [NREQ-1:0]          in_ack,
  output logic                     out_req,
  input  logic                     out_ack,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(NREQ)-1:0]  gnt_id,
  output logic                     busy
);
  localparam int IW = $clog2(NREQ);
  logic [NREQ-1:0] req_s;
  logic ack_s;
  logic [IW-1:0] ptr;
  logic [IW-1:0] nxt;
  state_t state;
`ifdef ARB_SYNC_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_sync
    sync2_n u_req (.clk(clk), .reset(reset), .d(in_req[i]), .q(req_s[i]));
  end
  sync2_n u_ack (.clk(clk), .reset(reset), .d(out_ack), .q(ack_s));
`else
  assign req_s = in_req;
  assign ack_s = out_ack;
`endif
  assign nxt = IW'(rr_next(32'(req_s), int'(ptr), NREQ));
  assign busy = state != IDLE;
  // Grant, downstream handshake, then wait for both sides to return to zero
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      ptr <= IW'(NREQ - 1);
      in_ack <= '0;
      out_req <= 1'b0;
      out_data <= '0;
      gnt_id <= '0;
    end else begin
      case (state)
        IDLE:
          if (|req_s) begin
            out_data <= in_data[nxt*DATA_W +: DATA_W];
            gnt_id <= nxt;
            out_req <= 1'b1;
            state <= OUT_REQ;
          end
        OUT_REQ:
          if (ack_s) begin
            out_req <= 1'b0;
            in_ack <= NREQ'(1) << gnt_id;
            state <= RTZ;
          end
        RTZ:
          if (!ack_s && !req_s[gnt_id]) begin
            in_ack <= '0;
            ptr <= gnt_id;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_hs4_rr_arbiter.sv
// tb_hs4_rr_arbiter: directed vector table plus handwritten fairness, reset and latency sequences
module tb_hs4_rr_arbiter;
`ifdef ARB_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  logic clk = 0;
  logic reset = 0;
  logic [3:0] in_req = 0;
  logic [31:0] in_data = {8'h3C, 8'hA5, 8'h22, 8'h11};
  logic [3:0] in_ack;
  logic out_req;
  logic out_ack = 0;
  logic [7:0] out_data;
  logic [1:0] gnt_id;
  logic busy;
  int errors = 0;
  int checks = 0;
  logic [7:0] dat [4] = '{8'h11, 8'h22, 8'hA5, 8'h3C};

  hs4_rr_arbiter dut (
    .clk(clk), .reset(reset), .in_req(in_req), .in_data(in_data), .in_ack(in_ack),
    .out_req(out_req), .out_ack(out_ack), .out_data(out_data), .gnt_id(gnt_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic ack;
    logic e_oreq;
    logic [3:0] e_iack;
    logic [1:0] e_gnt;
    logic [7:0] e_data;
    logic e_busy;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_oreq(input string name);
    for (int i = 0; i < 20 && !out_req; i++) tick();
    chk(name, 32'(out_req), 1);
  endtask

  task automatic wait_iack(input string name);
    for (int i = 0; i < 20 && in_ack == 0; i++) tick();
    chk(name, 32'(in_ack != 0), 1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 20 && busy; i++) tick();
    chk(name, 32'(busy), 0);
  endtask

  task automatic do_reset();
    in_req = 0;
    out_ack = 0;
    reset = 0;
    tick();
    tick();
    reset = 1;
  endtask

  vec_t v [17];
  int n;
  int g;

  initial begin
    v[0]  = '{4'b0000, 0, 0, 4'b0000, 2'd0, 8'h00, 0};
    v[1]  = '{4'b0100, 0, 1, 4'b0000, 2'd2, 8'hA5, 1};
    v[2]  = '{4'b0100, 1, 0, 4'b0100, 2'd2, 8'hA5, 1};
    v[3]  = '{4'b0000, 1, 0, 4'b0100, 2'd2, 8'hA5, 1};
    v[4]  = '{4'b0000, 0, 0, 4'b0000, 2'd2, 8'hA5, 0};
    v[5]  = '{4'b1010, 0, 1, 4'b0000, 2'd3, 8'h3C, 1};
    v[6]  = '{4'b1010, 1, 0, 4'b1000, 2'd3, 8'h3C, 1};
    v[7]  = '{4'b0010, 0, 0, 4'b0000, 2'd3, 8'h3C, 0};
    v[8]  = '{4'b0010, 0, 1, 4'b0000, 2'd1, 8'h22, 1};
    v[9]  = '{4'b0010, 1, 0, 4'b0010, 2'd1, 8'h22, 1};
    v[10] = '{4'b0000, 0, 0, 4'b0000, 2'd1, 8'h22, 0};
    v[11] = '{4'b1010, 0, 1, 4'b0000, 2'd3, 8'h3C, 1};
    v[12] = '{4'b1010, 1, 0, 4'b1000, 2'd3, 8'h3C, 1};
    v[13] = '{4'b0010, 0, 0, 4'b0000, 2'd3, 8'h3C, 0};
    v[14] = '{4'b0010, 0, 1, 4'b0000, 2'd1, 8'h22, 1};
    v[15] = '{4'b0010, 1, 0, 4'b0010, 2'd1, 8'h22, 1};
    v[16] = '{4'b0000, 0, 0, 4'b0000, 2'd1, 8'h22, 0};

    in_req = 4'b1111;
    out_ack = 1;
    tick();
    tick();
    chk("rst_out_req", 32'(out_req), 0);
    chk("rst_in_ack", 32'(in_ack), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_gnt_id", 32'(gnt_id), 0);
    chk("rst_busy", 32'(busy), 0);
    in_req = 0;
    out_ack = 0;
    reset = 1;

    for (int k = 0; k < 17; k++) begin
      in_req = v[k].req;
      out_ack = v[k].ack;
      for (int i = 0; i < LAT; i++) tick();
      chk($sformatf("vec%0d_out_req", k), 32'(out_req), 32'(v[k].e_oreq));
      chk($sformatf("vec%0d_in_ack", k), 32'(in_ack), 32'(v[k].e_iack));
      chk($sformatf("vec%0d_gnt_id", k), 32'(gnt_id), 32'(v[k].e_gnt));
      chk($sformatf("vec%0d_out_data", k), 32'(out_data), 32'(v[k].e_data));
      chk($sformatf("vec%0d_busy", k), 32'(busy), 32'(v[k].e_busy));
    end

    do_reset();
    in_req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      wait_oreq($sformatf("fair%0d_req_timeout", k));
      g = int'(gnt_id);
      chk($sformatf("fair%0d_gnt", k), 32'(gnt_id), 32'(k % 4));
      chk($sformatf("fair%0d_data", k), 32'(out_data), 32'(dat[k % 4]));
      out_ack = 1;
      wait_iack($sformatf("fair%0d_ack_timeout", k));
      chk($sformatf("fair%0d_in_ack", k), 32'(in_ack), 32'(4'b0001 << (k % 4)));
      in_req[g] = 0;
      out_ack = 0;
      wait_idle($sformatf("fair%0d_idle_timeout", k));
      in_req[g] = 1;
    end

    do_reset();
    in_req = 4'b1000;
    wait_oreq("mid_req_timeout");
    in_req = 4'b1010;
    #2 reset = 0;
    #1;
    chk("mid_out_req_async", 32'(out_req), 0);
    chk("mid_busy_async", 32'(busy), 0);
    chk("mid_gnt_async", 32'(gnt_id), 0);
    tick();
    reset = 1;
    wait_oreq("post_rst_timeout");
    chk("post_rst_gnt", 32'(gnt_id), 1);
    out_ack = 1;
    wait_iack("rtz_ack_timeout");
    chk("rtz_in_ack", 32'(in_ack), 32'(4'b0010));
    #2 reset = 0;
    #1;
    chk("rtz_in_ack_async", 32'(in_ack), 0);

    do_reset();
    tick();
    in_req = 4'b0001;
    n = 0;
    while (!out_req && n < 10) begin
      tick();
      n++;
    end
    chk("latency_edges", 32'(n), 32'(LAT));
    out_ack = 1;
    wait_iack("lat_ack_timeout");
    in_req = 0;
    out_ack = 0;
    wait_idle("lat_idle_timeout");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
